seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the calculator's multiplexed seven-segment drive (result / decimalpoint / nandos).
- Samples the scanned segment bus and reconstructs the four displayed characters plus decimal points.
- Publishes each complete, consistent frame with a one-cycle valid strobe.
- Used as an on-board display monitor and as the scoreboard front end in calculator benches.

---
 rtl/seg_scan_pkg.sv | 63 ++++++
 rtl/seg7_char_decode.sv | 34 +++
 rtl/seg_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the scanned seven-segment receiver.
package seg_scan_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Character codes for the non-numeric symbols
   localparam logic [3:0] CH_MINUS = 4'hA;
   localparam logic [3:0] CH_ERR   = 4'hE;
   localparam logic [3:0] CH_BLANK = 4'hF;

   localparam int NUM_DIGITS = 4;

   // Frame assembly states
   typedef enum logic {
      ST_IDLE,
      ST_COLLECT
   } state_t;

   // One registered snapshot of the display bus
   typedef struct packed {
      logic [3:0] nandos;
      logic [6:0] seg;
      logic       dpN;
   } sample_t;

   // True when exactly one anode enable is driven low
   function automatic logic oneAnodeLow(input logic [3:0] an);
      logic ok;
      ok = 1'b0;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Slot index of the single low anode (0 = rightmost)
   function automatic logic [1:0] anodeIndex(input logic [3:0] an);
      logic [1:0] idx;
      idx = 2'd0;
      case (an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational translation of an active-low segment pattern into a character code.
module seg7_char_decode
   import seg_scan_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic [3:0] o_char,
   output logic       o_err
);

   // Table lookup; anything not in the table is reported as an error character
   always_comb begin
      o_char = CH_ERR;
      o_err  = 1'b0;
      case (i_seg)
         SEG_0:     o_char = 4'h0;
         SEG_1:     o_char = 4'h1;
         SEG_2:     o_char = 4'h2;
         SEG_3:     o_char = 4'h3;
         SEG_4:     o_char = 4'h4;
         SEG_5:     o_char = 4'h5;
         SEG_6:     o_char = 4'h6;
         SEG_7:     o_char = 4'h7;
         SEG_8:     o_char = 4'h8;
         SEG_9:     o_char = 4'h9;
         SEG_MINUS: o_char = CH_MINUS;
         SEG_BLANK: o_char = CH_BLANK;
         default: begin
            o_char = CH_ERR;
            o_err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the four characters and decimal points shown on a multiplexed
// seven-segment display and publishes each complete frame with a strobe.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] result,
   input  logic       decimalpoint,
   input  logic [3:0] nandos,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic [3:0] dp_mask,
   output logic       frame_valid,
   output logic       frame_changed,
   output logic       seg_err,
   output logic       timeout
);

   localparam int               SET_W        = $clog2(SETTLE_CYCLES + 1);
   localparam logic [SET_W-1:0] SETTLE_MAX   = SET_W'(SETTLE_CYCLES);
   localparam logic [SET_W-1:0] SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   sample_t                 r_sample;
   sample_t                 r_prev;
   logic [SET_W-1:0]        r_stable;
   state_t                  r_state;
   state_t                  w_nextState;
   logic [3:0]              r_mask;
   logic [3:0]              w_maskNext;
   logic [CNT_W-1:0]        r_tcnt;
   logic [CNT_W-1:0]        w_tcntNext;
   logic [NUM_DIGITS-1:0][3:0] r_slotChar;
   logic [NUM_DIGITS-1:0]   r_slotDp;

   logic                    w_match;
   logic                    w_capture;
   logic [1:0]              w_slotIdx;
   logic [3:0]              w_slotBit;
   logic [3:0]              w_char;
   logic                    w_charErr;
   logic                    w_slotWrite;
   logic                    w_publish;
   logic                    w_timeoutHit;
   logic                    w_frameDiff;

   // A dwell sample counts only if it repeats the previous one on a single anode
   assign w_match   = (r_sample == r_prev) && oneAnodeLow(r_sample.nandos);
   assign w_capture = w_match && (r_stable == SETTLE_LAST);
   assign w_slotIdx = anodeIndex(r_sample.nandos);
   assign w_slotBit = ~r_sample.nandos;

   seg7_char_decode u_decode (
      .i_seg  (r_sample.seg),
      .o_char (w_char),
      .o_err  (w_charErr)
   );

   // Register the raw bus and keep one sample of history for the stability check
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample <= '1;
         r_prev   <= '1;
      end else begin
         r_sample <= sample_t'({nandos, result, decimalpoint});
         r_prev   <= r_sample;
      end
   end

   // Count matching samples; saturating so a long dwell captures only once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stable <= '0;
      end else if (!w_match) begin
         r_stable <= '0;
      end else if (r_stable != SETTLE_MAX) begin
         r_stable <= r_stable + 1'b1;
      end
   end

   // Frame assembly: a full mask publishes on the following edge, a capture
   // restarts the idle timer, and an expired timer drops the partial frame
   always_comb begin
      w_nextState  = r_state;
      w_maskNext   = r_mask;
      w_tcntNext   = r_tcnt;
      w_slotWrite  = 1'b0;
      w_publish    = 1'b0;
      w_timeoutHit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_tcntNext = '0;
            if (w_capture) begin
               w_slotWrite = 1'b1;
               w_maskNext  = r_mask | w_slotBit;
               w_nextState = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (r_mask == 4'b1111) begin
               w_publish   = 1'b1;
               w_maskNext  = '0;
               w_tcntNext  = '0;
               w_nextState = ST_IDLE;
            end else if (w_capture) begin
               w_slotWrite = 1'b1;
               w_maskNext  = r_mask | w_slotBit;
               w_tcntNext  = '0;
            end else if (r_tcnt == TIMEOUT_LAST) begin
               w_timeoutHit = 1'b1;
               w_maskNext   = '0;
               w_tcntNext   = '0;
               w_nextState  = ST_IDLE;
            end else begin
               w_tcntNext = r_tcnt + 1'b1;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
            w_maskNext  = '0;
            w_tcntNext  = '0;
         end
      endcase
   end

   // State, capture mask and idle timer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_mask  <= '0;
         r_tcnt  <= '0;
      end else begin
         r_state <= w_nextState;
         r_mask  <= w_maskNext;
         r_tcnt  <= w_tcntNext;
      end
   end

   // Slot buffer is indexed by anode position so scan order does not matter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slotChar <= {NUM_DIGITS{CH_BLANK}};
         r_slotDp   <= '0;
      end else if (w_slotWrite) begin
         r_slotChar[w_slotIdx] <= w_char;
         r_slotDp[w_slotIdx]   <= ~r_sample.dpN;
      end
   end

   assign w_frameDiff = {r_slotChar[3], r_slotChar[2], r_slotChar[1], r_slotChar[0], r_slotDp}
                     != {digit1, digit2, digit3, digit4, dp_mask};

   // Published frame, strobes and the sticky decode error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit1        <= CH_BLANK;
         digit2        <= CH_BLANK;
         digit3        <= CH_BLANK;
         digit4        <= CH_BLANK;
         dp_mask       <= '0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         seg_err       <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         frame_valid   <= w_publish;
         frame_changed <= w_publish && w_frameDiff;
         timeout       <= w_timeoutHit;
         seg_err       <= seg_err | (w_slotWrite & w_charErr);
         if (w_publish) begin
            digit1  <= r_slotChar[3];
            digit2  <= r_slotChar[2];
            digit3  <= r_slotChar[1];
            digit4  <= r_slotChar[0];
            dp_mask <= r_slotDp;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench: a behavioural model of the display receiver is compared
// against the DUT on every cycle, with literal checks pinning key frames.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

   localparam int SETTLE = 4;
   localparam int TMO    = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] result = 7'b1111111;
   logic       decimalpoint = 1'b1;
   logic [3:0] nandos = 4'b1111;
   logic [3:0] digit1, digit2, digit3, digit4, dp_mask;
   logic       frame_valid, frame_changed, seg_err, timeout;

   seg_scan_decoder #(
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TMO),
      .CNT_W          (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .result        (result),
      .decimalpoint  (decimalpoint),
      .nandos        (nandos),
      .digit1        (digit1),
      .digit2        (digit2),
      .digit3        (digit3),
      .digit4        (digit4),
      .dp_mask       (dp_mask),
      .frame_valid   (frame_valid),
      .frame_changed (frame_changed),
      .seg_err       (seg_err),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int frameCount = 0;
   int changedCount = 0;
   int timeoutCount = 0;
   bit started = 1'b0;

   logic [6:0] digitPat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   // Model state: the last latched bus word and how long it has been held
   logic [11:0] mLast;
   int          mRun;
   logic [3:0]  mChar [4];
   logic [3:0]  mDp;
   logic [3:0]  mFilled;
   bit          mPending, mCollecting;
   int          mTimer;
   logic [3:0]  eDigit [4];
   logic [3:0]  eDp;
   logic        eFv, eFc, eTo, eErr;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] patOf(input logic [3:0] ch);
      logic [6:0] p;
      if (ch <= 4'd9)       p = digitPat[int'(ch)];
      else if (ch == 4'hA)  p = 7'b0111111;
      else if (ch == 4'hF)  p = 7'b1111111;
      else                  p = 7'b1010101;
      return p;
   endfunction

   task automatic modelDecode(input logic [6:0] p, output logic [3:0] ch, output logic er);
      ch = 4'hE;
      er = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (p == digitPat[i]) begin
            ch = 4'(i);
            er = 1'b0;
         end
      end
      if (p == 7'b0111111) begin ch = 4'hA; er = 1'b0; end
      if (p == 7'b1111111) begin ch = 4'hF; er = 1'b0; end
   endtask

   task automatic modelReset();
      mLast = 12'hFFF;
      mRun = 0;
      for (int i = 0; i < 4; i++) begin
         mChar[i]  = 4'hF;
         eDigit[i] = 4'hF;
      end
      mDp = 4'h0;
      mFilled = 4'h0;
      mPending = 1'b0;
      mCollecting = 1'b0;
      mTimer = 0;
      eDp = 4'h0;
      eFv = 1'b0;
      eFc = 1'b0;
      eTo = 1'b0;
      eErr = 1'b0;
   endtask

   // One clock edge of the model: x is the bus word present at this edge
   task automatic modelStep(input logic [11:0] x);
      bit cap;
      logic [11:0] capX;
      logic [3:0] ch;
      logic er;
      bit valid;
      int idx;
      bit differ;
      cap  = (mRun == SETTLE + 1);
      capX = mLast;
      valid = ($countones(~x[11:8]) == 1);
      if (valid && x == mLast) mRun = (mRun < SETTLE + 2) ? mRun + 1 : mRun;
      else                     mRun = valid ? 1 : 0;
      mLast = x;
      eFv = 1'b0;
      eFc = 1'b0;
      eTo = 1'b0;
      if (mPending) begin
         differ = ({mChar[3], mChar[2], mChar[1], mChar[0], mDp} !=
                   {eDigit[3], eDigit[2], eDigit[1], eDigit[0], eDp});
         for (int i = 0; i < 4; i++) eDigit[i] = mChar[i];
         eDp = mDp;
         eFv = 1'b1;
         eFc = differ;
         mFilled = 4'h0;
         mPending = 1'b0;
         mCollecting = 1'b0;
         mTimer = 0;
      end else if (cap) begin
         idx = 0;
         for (int i = 0; i < 4; i++) if (capX[8+i] == 1'b0) idx = i;
         modelDecode(capX[7:1], ch, er);
         mChar[idx] = ch;
         mDp[idx] = ~capX[0];
         mFilled[idx] = 1'b1;
         if (er) eErr = 1'b1;
         mCollecting = 1'b1;
         mTimer = 0;
         if (mFilled == 4'hF) mPending = 1'b1;
      end else if (mCollecting) begin
         mTimer++;
         if (mTimer == TMO) begin
            eTo = 1'b1;
            mFilled = 4'h0;
            mCollecting = 1'b0;
            mTimer = 0;
         end
      end
   endtask

   // Model advances on every clock edge and resets with the DUT
   initial begin
      modelReset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) modelReset();
         else     modelStep({nandos, result, decimalpoint});
      end
   end

   // Compare DUT against the model away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (started && !rst) begin
            checkOutput("frame_outputs", {digit1, digit2, digit3, digit4, dp_mask},
                        {eDigit[3], eDigit[2], eDigit[1], eDigit[0], eDp});
            checkOutput("strobes", {frame_valid, frame_changed, timeout}, {eFv, eFc, eTo});
            checkOutput("seg_err", seg_err, eErr);
            if (frame_valid)   frameCount++;
            if (frame_changed) changedCount++;
            if (timeout)       timeoutCount++;
         end
      end
   end

   task automatic applyStimulus(input logic [3:0] an, input logic [6:0] pat, input logic dpLow, input int dwell);
      nandos = an;
      result = pat;
      decimalpoint = ~dpLow;
      repeat (dwell) @(negedge clk);
   endtask

   task automatic idle(input int n);
      applyStimulus(4'b1111, 7'b1111111, 1'b0, n);
   endtask

   // Scan a word {digit1,digit2,digit3,digit4}; reverse starts at nandos[0]
   task automatic scanWord(input logic [15:0] word, input logic [3:0] dpm, input bit reverse, input int dwell);
      int pos;
      for (int k = 0; k < 4; k++) begin
         pos = reverse ? k : 3 - k;
         applyStimulus(~(4'b0001 << pos), patOf(word[pos*4 +: 4]), dpm[pos], dwell);
      end
   endtask

   task automatic randomPhase(input int frames);
      int ord [4];
      int tmp, j, dwell;
      logic [3:0] ch;
      logic [6:0] pat;
      for (int f = 0; f < frames; f++) begin
         ord = '{0, 1, 2, 3};
         for (int i = 3; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
         end
         for (int k = 0; k < 4; k++) begin
            dwell = $urandom_range(10, 3);
            case ($urandom_range(11, 0))
               0: ch = 4'hA;
               1: ch = 4'hF;
               default: ch = 4'($urandom_range(9, 0));
            endcase
            pat = patOf(ch);
            if ($urandom_range(15, 0) == 0) pat = 7'($urandom);
            if ($urandom_range(11, 0) == 0)
               applyStimulus(4'($urandom_range(15, 0)), pat, 1'($urandom), dwell);
            else
               applyStimulus(~(4'b0001 << ord[k]), pat, 1'($urandom), dwell);
         end
         idle($urandom_range(24, 1));
      end
   endtask

   // Global bound on run time
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   int f0, c0, t0;

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      started = 1'b1;
      @(negedge clk);
      checkOutput("reset_outputs", {digit1, digit2, digit3, digit4, dp_mask}, 32'hFFFF0);
      checkOutput("reset_flags", {frame_valid, frame_changed, seg_err, timeout}, 32'h0);

      $display("[TB] short dwell never captures");
      scanWord(16'h1234, 4'h0, 1'b0, 3);
      idle(30);
      checkOutput("short_dwell_frames", frameCount, 0);
      checkOutput("short_dwell_hold", {digit1, digit2, digit3, digit4, dp_mask}, 32'hFFFF0);

      $display("[TB] repeated scan of 1234");
      f0 = frameCount; c0 = changedCount;
      for (int s = 0; s < 3; s++) begin
         scanWord(16'h1234, 4'h0, 1'b0, 8);
         idle(4);
      end
      checkOutput("scan1234_frames", frameCount - f0, 3);
      checkOutput("scan1234_changed", changedCount - c0, 1);
      checkOutput("scan1234_digits", {digit1, digit2, digit3, digit4, dp_mask}, 32'h12340);
      checkOutput("model_pin_1234", {eDigit[3], eDigit[2], eDigit[1], eDigit[0]}, 32'h1234);

      $display("[TB] reversed scan of -0.5");
      c0 = changedCount;
      scanWord(16'hA05F, 4'b0100, 1'b1, 8);
      idle(4);
      checkOutput("minus_digits", {digit1, digit2, digit3, digit4, dp_mask}, 32'hA05F4);
      checkOutput("minus_changed", changedCount - c0, 1);

      $display("[TB] partial frame timeout");
      f0 = frameCount; t0 = timeoutCount;
      applyStimulus(4'b0111, patOf(4'h5), 1'b0, 8);
      applyStimulus(4'b1011, patOf(4'h6), 1'b0, 8);
      applyStimulus(4'b1101, patOf(4'h7), 1'b0, 8);
      idle(TMO + 5);
      checkOutput("timeout_pulses", timeoutCount - t0, 1);
      checkOutput("timeout_no_frame", frameCount - f0, 0);
      checkOutput("timeout_hold", {digit1, digit2, digit3, digit4, dp_mask}, 32'hA05F4);
      scanWord(16'h5678, 4'h0, 1'b0, 8);
      idle(4);
      checkOutput("after_timeout_digits", {digit1, digit2, digit3, digit4, dp_mask}, 32'h56780);

      $display("[TB] undecodable pattern");
      applyStimulus(4'b0111, patOf(4'h1), 1'b0, 8);
      applyStimulus(4'b1011, 7'b1010101, 1'b0, 8);
      applyStimulus(4'b1101, patOf(4'h2), 1'b0, 8);
      applyStimulus(4'b1110, patOf(4'h3), 1'b0, 8);
      idle(4);
      checkOutput("bad_pattern_digits", {digit1, digit2, digit3, digit4, dp_mask}, 32'h1E230);
      checkOutput("seg_err_set", seg_err, 1);
      scanWord(16'h1234, 4'h0, 1'b0, 8);
      idle(4);
      checkOutput("seg_err_sticky", seg_err, 1);
      checkOutput("clean_after_err", {digit1, digit2, digit3, digit4, dp_mask}, 32'h12340);

      $display("[TB] reset mid-frame");
      applyStimulus(4'b0111, patOf(4'h4), 1'b0, 8);
      applyStimulus(4'b1011, patOf(4'h3), 1'b0, 8);
      applyStimulus(4'b1101, patOf(4'h2), 1'b0, 3);
      #2 rst = 1'b1;
      nandos = 4'b1111;
      result = 7'b1111111;
      decimalpoint = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_outputs", {digit1, digit2, digit3, digit4, dp_mask}, 32'hFFFF0);
      checkOutput("midreset_seg_err", seg_err, 0);
      f0 = frameCount; c0 = changedCount;
      idle(10);
      scanWord(16'h9876, 4'h0, 1'b0, 8);
      idle(4);
      checkOutput("after_reset_frames", frameCount - f0, 1);
      checkOutput("after_reset_changed", changedCount - c0, 1);
      checkOutput("after_reset_digits", {digit1, digit2, digit3, digit4, dp_mask}, 32'h98760);

      $display("[TB] randomized scans");
      randomPhase(60);
      idle(TMO + 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
